// File: rtl/atm_session_if.sv
// ATM session controller bus: front-end (card reader, keypad, account loader)
// to controller, and controller to cash dispenser / printer / status.
// timeout_flag exists only when ATM_TIMEOUT_EN is defined.
interface atm_session_if #(
  parameter int PIN_W = 16,
  parameter int AMT_W = 16
);
  // front end -> controller
  logic             card_inserted;
  logic             acct_load;
  logic [PIN_W-1:0] pin_ref;
  logic [AMT_W-1:0] bal_in;
  logic             pin_valid;
  logic [PIN_W-1:0] pin_entry;
  logic             wd_req;
  logic [AMT_W-1:0] wd_amt;
  logic             receipt_req;
  logic             exit_req;
  // controller -> drivers / status
  logic             card_accepted;
  logic             pin_ok;
  logic             dispense_cash;
  logic [AMT_W-1:0] dispense_amt;
  logic             insufficient_funds;
  logic             print_receipt;
  logic             eject_card;
  logic             card_retained;
  logic [AMT_W-1:0] balance;
  logic [2:0]       tries_left;
  logic [2:0]       state_out;
`ifdef ATM_TIMEOUT_EN
  logic             timeout_flag;
`endif

  modport master (
`ifdef ATM_TIMEOUT_EN
    input  timeout_flag,
`endif
    output card_inserted, acct_load, pin_ref, bal_in, pin_valid, pin_entry,
           wd_req, wd_amt, receipt_req, exit_req,
    input  card_accepted, pin_ok, dispense_cash, dispense_amt,
           insufficient_funds, print_receipt, eject_card, card_retained,
           balance, tries_left, state_out
  );

  modport slave (
`ifdef ATM_TIMEOUT_EN
    output timeout_flag,
`endif
    input  card_inserted, acct_load, pin_ref, bal_in, pin_valid, pin_entry,
           wd_req, wd_amt, receipt_req, exit_req,
    output card_accepted, pin_ok, dispense_cash, dispense_amt,
           insufficient_funds, print_receipt, eject_card, card_retained,
           balance, tries_left, state_out
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card acceptance, PIN check with bounded retries and
// card retention, balance-checked withdrawal, optional receipt, card eject.
// Optional feature macro: ATM_TIMEOUT_EN (inactivity timeout + timeout_flag).
// All outputs are registered; state_out is the state register itself.
module atm_session_ctrl #(
  parameter int PIN_W       = 16,
  parameter int AMT_W       = 16,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  atm_session_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PIN     = 3'd1,
    ST_TXN     = 3'd2,
    ST_RECEIPT = 3'd3,
    ST_EJECT   = 3'd4,
    ST_RETAIN  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [PIN_W-1:0] pin_ref_q, pin_ref_d;
  logic [AMT_W-1:0] balance_q, balance_d;
  logic [2:0]       tries_q, tries_d;
  logic             retained_q, retained_d;
  logic             dispense_q, dispense_d;
  logic [AMT_W-1:0] disp_amt_q, disp_amt_d;
  logic             insuff_q, insuff_d;
  logic             print_q, print_d;
  logic             eject_q, eject_d;
  logic             accepted_q, accepted_d;
  logic             pin_ok_q, pin_ok_d;

  logic card_pull, pin_match, wd_fits, wd_over;
  assign card_pull = !bus.card_inserted;
  assign pin_match = (bus.pin_entry == pin_ref_q);
  // Unsigned full-width compare; the guard makes the debit underflow-free.
  assign wd_fits   = (bus.wd_amt != '0) && (bus.wd_amt <= balance_q);
  assign wd_over   = (bus.wd_amt > balance_q);

  logic timeout_hit;
`ifdef ATM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt_q;
  logic            timeout_q;
  logic            activity, in_session;
  assign activity    = bus.pin_valid | bus.wd_req | bus.receipt_req | bus.exit_req;
  assign in_session  = (state_q == ST_PIN) || (state_q == ST_TXN) || (state_q == ST_RECEIPT);
  assign timeout_hit = in_session && !activity && (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; priority is card pull > exit > timeout > pin/withdraw.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.card_inserted && !retained_q) state_d = ST_PIN;
      ST_PIN: begin
        if (card_pull)                state_d = ST_IDLE;
        else if (bus.exit_req)        state_d = ST_EJECT;
        else if (timeout_hit)         state_d = ST_EJECT;
        else if (bus.pin_valid) begin
          if (pin_match)              state_d = ST_TXN;
          else if (tries_q <= 3'd1)   state_d = ST_RETAIN;
        end
      end
      ST_TXN: begin
        if (card_pull)                  state_d = ST_IDLE;
        else if (bus.exit_req)          state_d = ST_EJECT;
        else if (timeout_hit)           state_d = ST_EJECT;
        else if (bus.wd_req && wd_fits) state_d = ST_RECEIPT;
      end
      ST_RECEIPT: begin
        if (card_pull)                                state_d = ST_IDLE;
        else if (bus.receipt_req || bus.exit_req)     state_d = ST_EJECT;
        else if (timeout_hit)                         state_d = ST_EJECT;
      end
      ST_EJECT:   if (card_pull) state_d = ST_IDLE;
      ST_RETAIN:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values, registered below.
  always_comb begin
    pin_ref_d  = pin_ref_q;
    balance_d  = balance_q;
    tries_d    = tries_q;
    retained_d = retained_q;
    dispense_d = 1'b0;
    disp_amt_d = '0;
    insuff_d   = 1'b0;
    print_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.acct_load) begin
          pin_ref_d  = bus.pin_ref;
          balance_d  = bus.bal_in;
          retained_d = 1'b0;
        end
        if (bus.card_inserted && !retained_q) tries_d = 3'(MAX_TRIES);
      end
      ST_PIN:
        if (!card_pull && !bus.exit_req && bus.pin_valid && !pin_match)
          tries_d = tries_q - 3'd1;
      ST_TXN:
        if (!card_pull && !bus.exit_req && bus.wd_req) begin
          if (wd_fits) begin
            balance_d  = balance_q - bus.wd_amt;
            dispense_d = 1'b1;
            disp_amt_d = bus.wd_amt;
          end else if (wd_over) begin
            insuff_d = 1'b1;
          end
        end
      ST_RECEIPT:
        if (!card_pull && bus.receipt_req) print_d = 1'b1;
      default: ;
    endcase
    if (state_d == ST_RETAIN) retained_d = 1'b1;
    eject_d    = (state_d == ST_EJECT) && (state_q != ST_EJECT);
    accepted_d = (state_d == ST_PIN) || (state_d == ST_TXN) ||
                 (state_d == ST_RECEIPT) || (state_d == ST_EJECT);
    pin_ok_d   = (state_d == ST_TXN) || (state_d == ST_RECEIPT);
  end

  // Registered outputs and account datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pin_ref_q  <= '0;
      balance_q  <= '0;
      tries_q    <= 3'(MAX_TRIES);
      retained_q <= 1'b0;
      dispense_q <= 1'b0;
      disp_amt_q <= '0;
      insuff_q   <= 1'b0;
      print_q    <= 1'b0;
      eject_q    <= 1'b0;
      accepted_q <= 1'b0;
      pin_ok_q   <= 1'b0;
    end else begin
      pin_ref_q  <= pin_ref_d;
      balance_q  <= balance_d;
      tries_q    <= tries_d;
      retained_q <= retained_d;
      dispense_q <= dispense_d;
      disp_amt_q <= disp_amt_d;
      insuff_q   <= insuff_d;
      print_q    <= print_d;
      eject_q    <= eject_d;
      accepted_q <= accepted_d;
      pin_ok_q   <= pin_ok_d;
    end
  end

`ifdef ATM_TIMEOUT_EN
  // Inactivity counter: restarts on any state change or keypad/request activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= timeout_hit && bus.card_inserted;
      if (!in_session || activity || (state_d != state_q)) idle_cnt_q <= '0;
      else                                                 idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
  assign bus.timeout_flag = timeout_q;
`endif

  assign bus.card_accepted      = accepted_q;
  assign bus.pin_ok             = pin_ok_q;
  assign bus.dispense_cash      = dispense_q;
  assign bus.dispense_amt       = disp_amt_q;
  assign bus.insufficient_funds = insuff_q;
  assign bus.print_receipt      = print_q;
  assign bus.eject_card         = eject_q;
  assign bus.card_retained      = retained_q;
  assign bus.balance            = balance_q;
  assign bus.tries_left         = tries_q;
  assign bus.state_out          = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Testbench for atm_session_ctrl (default build, ATM_TIMEOUT_EN undefined).
// Directed stimulus pushes expected pulse events into a scoreboard queue; a
// monitor pops and compares whenever the DUT raises any one-cycle pulse.
module tb_atm_session_ctrl;
  localparam int PIN_W = 16;
  localparam int AMT_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  atm_session_if #(.PIN_W(PIN_W), .AMT_W(AMT_W)) bus ();

  atm_session_ctrl #(
    .PIN_W(PIN_W), .AMT_W(AMT_W), .MAX_TRIES(3), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic             disp;
    logic [AMT_W-1:0] amt;
    logic             insuff;
    logic             prt;
    logic             ej;
    logic [AMT_W-1:0] bal;
    logic [2:0]       st;
  } ev_t;

  ev_t sb[$];
  ev_t got, want;
  int  vectors     = 0;
  int  miscompares = 0;

  function automatic string fmt(ev_t e);
    return $sformatf("disp=%0b amt=%0d insuff=%0b prt=%0b ej=%0b bal=%0d st=%0d",
                     e.disp, e.amt, e.insuff, e.prt, e.ej, e.bal, e.st);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic d, input int amt, input logic i, input logic p,
                           input logic e, input int bal, input int st);
    ev_t x;
    x.disp = d; x.amt = AMT_W'(amt); x.insuff = i; x.prt = p; x.ej = e;
    x.bal = AMT_W'(bal); x.st = 3'(st);
    sb.push_back(x);
  endtask

  // Monitor: every cycle with a pulse output high is one scoreboard event.
  always @(negedge clk) begin
    if (!reset && (bus.dispense_cash || bus.insufficient_funds ||
                   bus.print_receipt || bus.eject_card)) begin
      got.disp = bus.dispense_cash;  got.amt = bus.dispense_amt;
      got.insuff = bus.insufficient_funds; got.prt = bus.print_receipt;
      got.ej = bus.eject_card; got.bal = bus.balance; got.st = bus.state_out;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got {%s}, expected no event (t=%0t)", fmt(got), $time);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL event: got {%s}, expected {%s} (t=%0t)", fmt(got), fmt(want), $time);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic step();
    cyc();
    bus.acct_load = 1'b0; bus.pin_valid = 1'b0; bus.wd_req = 1'b0;
    bus.receipt_req = 1'b0; bus.exit_req = 1'b0;
  endtask

  task automatic load(input logic [PIN_W-1:0] pin, input logic [AMT_W-1:0] bal);
    bus.acct_load = 1'b1; bus.pin_ref = pin; bus.bal_in = bal; step();
  endtask

  task automatic enter_pin(input logic [PIN_W-1:0] pin);
    bus.pin_valid = 1'b1; bus.pin_entry = pin; step();
  endtask

  task automatic withdraw(input logic [AMT_W-1:0] amt);
    bus.wd_req = 1'b1; bus.wd_amt = amt; step();
  endtask

  task automatic open_txn();
    bus.card_inserted = 1'b1; step();
    enter_pin(16'h1234);
  endtask

  initial begin
    reset = 1'b1;
    bus.card_inserted = 1'b0; bus.acct_load = 1'b0; bus.pin_ref = '0; bus.bal_in = '0;
    bus.pin_valid = 1'b0; bus.pin_entry = '0; bus.wd_req = 1'b0; bus.wd_amt = '0;
    bus.receipt_req = 1'b0; bus.exit_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_state", bus.state_out, 0);
    check("rst_tries", bus.tries_left, 3);
    check("rst_balance", bus.balance, 0);
    check("rst_retained", bus.card_retained, 0);
    check("rst_accepted", bus.card_accepted, 0);

    // Load account, insert card, correct PIN
    load(16'h1234, 16'd500);
    check("load_balance", bus.balance, 500);
    check("load_state", bus.state_out, 0);
    bus.card_inserted = 1'b1; step();
    check("ins_state", bus.state_out, 1);
    check("ins_accepted", bus.card_accepted, 1);
    check("ins_tries", bus.tries_left, 3);
    enter_pin(16'h1234);
    check("pin_state", bus.state_out, 2);
    check("pin_ok", bus.pin_ok, 1);
    check("pin_tries", bus.tries_left, 3);

    // Withdraw 200 of 500, then receipt and eject
    expect_ev(1, 200, 0, 0, 0, 300, 3);
    withdraw(16'd200);
    check("wd200_state", bus.state_out, 3);
    check("wd200_balance", bus.balance, 300);
    expect_ev(0, 0, 0, 1, 1, 300, 4);
    bus.receipt_req = 1'b1; step();
    check("rcpt_state", bus.state_out, 4);
    check("rcpt_accepted", bus.card_accepted, 1);
    step();
    check("eject_hold", bus.state_out, 4);
    bus.card_inserted = 1'b0; step();
    check("eject_idle", bus.state_out, 0);
    check("eject_accepted", bus.card_accepted, 0);

    // Zero amount ignored, overdraw refused, exact-balance withdrawal
    open_txn();
    withdraw(16'd0);
    check("wd0_state", bus.state_out, 2);
    expect_ev(0, 0, 1, 0, 0, 300, 2);
    withdraw(16'd301);
    check("wd301_state", bus.state_out, 2);
    check("wd301_balance", bus.balance, 300);
    expect_ev(1, 300, 0, 0, 0, 0, 3);
    withdraw(16'd300);
    check("wd300_balance", bus.balance, 0);
    expect_ev(0, 0, 0, 0, 1, 0, 4);
    bus.exit_req = 1'b1; step();
    check("exit_rcpt_state", bus.state_out, 4);
    bus.card_inserted = 1'b0; step();

    // Three wrong PINs -> retain, no eject; reinsertion ignored
    load(16'h1234, 16'd500);
    bus.card_inserted = 1'b1; step();
    enter_pin(16'h0000);
    check("wrong1_tries", bus.tries_left, 2);
    check("wrong1_state", bus.state_out, 1);
    enter_pin(16'h0000);
    check("wrong2_tries", bus.tries_left, 1);
    enter_pin(16'h0000);
    check("wrong3_tries", bus.tries_left, 0);
    check("wrong3_state", bus.state_out, 5);
    check("wrong3_retained", bus.card_retained, 1);
    step();
    check("retain_idle", bus.state_out, 0);
    step();
    check("retain_ignore", bus.state_out, 0);
    bus.card_inserted = 1'b0; step();
    bus.card_inserted = 1'b1; step();
    check("reinsert_ignore", bus.state_out, 0);
    check("reinsert_retained", bus.card_retained, 1);
    bus.card_inserted = 1'b0;
    load(16'h1234, 16'd500);
    check("load_clears_retained", bus.card_retained, 0);

    // One wrong then right PIN keeps the reduced try count
    bus.card_inserted = 1'b1; step();
    enter_pin(16'h4321);
    enter_pin(16'h1234);
    check("retry_state", bus.state_out, 2);
    check("retry_tries", bus.tries_left, 2);

    // Card pulled in TXN: straight to IDLE, no eject
    bus.card_inserted = 1'b0; step();
    check("pull_txn_state", bus.state_out, 0);
    check("pull_txn_pin_ok", bus.pin_ok, 0);

    // Card pull beats exit_req in PIN
    bus.card_inserted = 1'b1; step();
    bus.card_inserted = 1'b0; bus.exit_req = 1'b1; step();
    check("pull_beats_exit", bus.state_out, 0);

    // exit_req beats wd_req in TXN: eject, no dispense
    open_txn();
    expect_ev(0, 0, 0, 0, 1, 500, 4);
    bus.exit_req = 1'b1; bus.wd_req = 1'b1; bus.wd_amt = 16'd100; step();
    check("exit_wd_state", bus.state_out, 4);
    check("exit_wd_balance", bus.balance, 500);
    bus.card_inserted = 1'b0; step();

    // Asynchronous reset mid-session
    open_txn();
    expect_ev(1, 50, 0, 0, 0, 450, 3);
    withdraw(16'd50);
    @(negedge clk); #2;
    reset = 1'b1; #1;
    check("async_rst_state", bus.state_out, 0);
    check("async_rst_balance", bus.balance, 0);
    check("async_rst_tries", bus.tries_left, 3);
    check("async_rst_pin_ok", bus.pin_ok, 0);
    bus.card_inserted = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) step();

    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
